// File: rtl/obi_apb_bridge.sv
// OBI-to-APB bridge: one outstanding OBI request is turned into an APB
// SETUP/ACCESS transfer, with an optional wait-state timeout on ACCESS.
`timescale 1ns/1ps

module obi_apb_bridge #(
    parameter int AddrWidth     = 32,
    parameter int DataWidth     = 32,
    parameter int TimeoutCycles = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_i,
    output logic                   gnt_o,
    input  logic [AddrWidth-1:0]   addr_i,
    input  logic                   we_i,
    input  logic [DataWidth/8-1:0] be_i,
    input  logic [DataWidth-1:0]   wdata_i,
    output logic                   rvalid_o,
    output logic [DataWidth-1:0]   rdata_o,
    output logic                   err_o,
    output logic                   timeout_o,
    output logic [AddrWidth-1:0]   paddr_o,
    output logic                   psel_o,
    output logic                   penable_o,
    output logic                   pwrite_o,
    output logic [DataWidth-1:0]   pwdata_o,
    output logic [DataWidth/8-1:0] pstrb_o,
    input  logic [DataWidth-1:0]   prdata_i,
    input  logic                   pready_i,
    input  logic                   pslverr_i
);

    localparam int StrbWidth = DataWidth / 8;
    localparam int CntWidth  = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam logic [CntWidth-1:0]  CntMax    = CntWidth'(TimeoutCycles);
    localparam logic [AddrWidth-1:0] AlignMask = ~AddrWidth'(3);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_e;

    state_e                 state_q;
    logic [CntWidth-1:0]    cnt_q;
    logic [CntWidth-1:0]    cnt_d;
    logic                   tmo_hit;

    logic [AddrWidth-1:0]   paddr_q;
    logic                   psel_q;
    logic                   penable_q;
    logic                   pwrite_q;
    logic [DataWidth-1:0]   pwdata_q;
    logic [StrbWidth-1:0]   pstrb_q;
    logic                   rvalid_q;
    logic [DataWidth-1:0]   rdata_q;
    logic                   err_q;
    logic                   timeout_q;

    // Count is the number of wait cycles seen including the current one.
    assign cnt_d   = (cnt_q == CntMax) ? cnt_q : cnt_q + CntWidth'(1);
    assign tmo_hit = (TimeoutCycles != 0) && (cnt_d == CntMax);

    assign gnt_o = (state_q == IDLE) && !rst_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            paddr_q   <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            rvalid_q  <= 1'b0;
            timeout_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (req_i) begin
                        paddr_q   <= addr_i & AlignMask;
                        pwrite_q  <= we_i;
                        pwdata_q  <= wdata_i;
                        pstrb_q   <= we_i ? be_i : '0;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                        state_q   <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    cnt_q     <= '0;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    if (pready_i) begin
                        rdata_q   <= pwrite_q ? '0 : prdata_i;
                        err_q     <= pslverr_i;
                        rvalid_q  <= 1'b1;
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        state_q   <= RESP;
                    end else if (tmo_hit) begin
                        rdata_q   <= '0;
                        err_q     <= 1'b1;
                        rvalid_q  <= 1'b1;
                        timeout_q <= 1'b1;
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        state_q   <= RESP;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign paddr_o   = paddr_q;
    assign psel_o    = psel_q;
    assign penable_o = penable_q;
    assign pwrite_o  = pwrite_q;
    assign pwdata_o  = pwdata_q;
    assign pstrb_o   = pstrb_q;
    assign rvalid_o  = rvalid_q;
    assign rdata_o   = rdata_q;
    assign err_o     = err_q;
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_obi_apb_bridge.sv
// Bench for obi_apb_bridge: transaction-level timeline model checked every
// cycle, plus hand-computed literal checks on two instances.
`timescale 1ns/1ps

module tb_obi_apb_bridge;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SW   = 4;
    localparam int N    = 2;
    localparam int MAXC = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          req     [N];
    logic [AW-1:0] addr    [N];
    logic          we      [N];
    logic [SW-1:0] be      [N];
    logic [DW-1:0] wdata   [N];
    logic [DW-1:0] prdata  [N];
    logic          pready  [N];
    logic          pslverr [N];
    logic          gnt     [N];
    logic          rvalid  [N];
    logic [DW-1:0] rdata   [N];
    logic          err     [N];
    logic          tmo     [N];
    logic [AW-1:0] paddr   [N];
    logic          psel    [N];
    logic          penable [N];
    logic          pwrite  [N];
    logic [DW-1:0] pwdata  [N];
    logic [SW-1:0] pstrb   [N];
    int            rdy_cyc [N];

    assign pready[0] = (cyc == rdy_cyc[0]);
    assign pready[1] = (cyc == rdy_cyc[1]);

    obi_apb_bridge #(.AddrWidth(AW), .DataWidth(DW), .TimeoutCycles(255)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .req_i(req[0]), .gnt_o(gnt[0]),
        .addr_i(addr[0]), .we_i(we[0]), .be_i(be[0]), .wdata_i(wdata[0]),
        .rvalid_o(rvalid[0]), .rdata_o(rdata[0]), .err_o(err[0]),
        .timeout_o(tmo[0]), .paddr_o(paddr[0]), .psel_o(psel[0]),
        .penable_o(penable[0]), .pwrite_o(pwrite[0]), .pwdata_o(pwdata[0]),
        .pstrb_o(pstrb[0]), .prdata_i(prdata[0]), .pready_i(pready[0]),
        .pslverr_i(pslverr[0])
    );

    obi_apb_bridge #(.AddrWidth(AW), .DataWidth(DW), .TimeoutCycles(4)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .req_i(req[1]), .gnt_o(gnt[1]),
        .addr_i(addr[1]), .we_i(we[1]), .be_i(be[1]), .wdata_i(wdata[1]),
        .rvalid_o(rvalid[1]), .rdata_o(rdata[1]), .err_o(err[1]),
        .timeout_o(tmo[1]), .paddr_o(paddr[1]), .psel_o(psel[1]),
        .penable_o(penable[1]), .pwrite_o(pwrite[1]), .pwdata_o(pwdata[1]),
        .pstrb_o(pstrb[1]), .prdata_i(prdata[1]), .pready_i(pready[1]),
        .pslverr_i(pslverr[1])
    );

    // Expected per-cycle timeline, one row per instance.
    bit          m_busy  [N][MAXC];
    bit          m_psel  [N][MAXC];
    bit          m_pen   [N][MAXC];
    bit          m_rv    [N][MAXC];
    bit          m_tmo   [N][MAXC];
    bit          m_err   [N][MAXC];
    bit          m_pwr   [N][MAXC];
    bit [AW-1:0] m_paddr [N][MAXC];
    bit [DW-1:0] m_pwd   [N][MAXC];
    bit [DW-1:0] m_rdata [N][MAXC];
    bit [SW-1:0] m_pstrb [N][MAXC];

    int total = 0;
    int bad   = 0;
    bit run   = 1'b0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (run && cyc < MAXC) begin
            for (int k = 0; k < N; k++) begin
                chk($sformatf("gnt%0d", k), gnt[k], !m_busy[k][cyc] && !rst);
                chk($sformatf("psel%0d", k), psel[k], m_psel[k][cyc]);
                chk($sformatf("penable%0d", k), penable[k], m_pen[k][cyc]);
                chk($sformatf("rvalid%0d", k), rvalid[k], m_rv[k][cyc]);
                chk($sformatf("timeout%0d", k), tmo[k], m_tmo[k][cyc]);
                if (m_psel[k][cyc]) begin
                    chk($sformatf("paddr%0d", k), paddr[k], m_paddr[k][cyc]);
                    chk($sformatf("pwrite%0d", k), pwrite[k], m_pwr[k][cyc]);
                    chk($sformatf("pwdata%0d", k), pwdata[k], m_pwd[k][cyc]);
                    chk($sformatf("pstrb%0d", k), pstrb[k], m_pstrb[k][cyc]);
                end
                if (m_rv[k][cyc]) begin
                    chk($sformatf("rdata%0d", k), rdata[k], m_rdata[k][cyc]);
                    chk($sformatf("err%0d", k), err[k], m_err[k][cyc]);
                end
            end
        end
    end

    // Stops at the negedge of cycle c.
    task automatic at(int c);
        int n = 0;
        @(negedge clk);
        while (cyc < c && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (cyc != c) chk("at_bound", cyc, c);
    endtask

    // Raises a request, waits for its grant and books the expected timeline.
    // Called just after a rising edge; returns just after the edge ending
    // the grant cycle.
    task automatic issue(int k, bit w, logic [AW-1:0] a, logic [SW-1:0] b,
                         logic [DW-1:0] wd, logic [DW-1:0] rd, bit se,
                         int waits, output int g);
        int acc;
        int lim;
        bit ab;
        addr[k] = a; we[k] = w; be[k] = b; wdata[k] = wd;
        prdata[k] = rd; pslverr[k] = se; req[k] = 1'b1;
        g = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (gnt[k] === 1'b1) begin
                g = cyc;
                break;
            end
        end
        if (g < 0) begin
            chk("grant_bound", 0, 1);
            req[k] = 1'b0;
            return;
        end
        lim = (k == 0) ? 255 : 4;
        ab  = (waits >= lim);
        acc = ab ? lim : waits + 1;
        rdy_cyc[k] = g + 2 + waits;
        for (int c = g + 1; c <= g + 2 + acc && c < MAXC; c++) begin
            m_busy[k][c] = 1'b1;
            if (c <= g + 1 + acc) begin
                m_psel[k][c]  = 1'b1;
                m_pen[k][c]   = (c >= g + 2);
                m_paddr[k][c] = (a / 4) * 4;
                m_pwr[k][c]   = w;
                m_pwd[k][c]   = wd;
                m_pstrb[k][c] = w ? b : 4'h0;
            end else begin
                m_rv[k][c]    = 1'b1;
                m_tmo[k][c]   = ab;
                m_err[k][c]   = ab || se;
                m_rdata[k][c] = (ab || w) ? 32'h0 : rd;
            end
        end
        @(posedge clk);
        #1;
        req[k] = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int g2;
        for (int k = 0; k < N; k++) begin
            req[k] = 0; addr[k] = 0; we[k] = 0; be[k] = 0;
            wdata[k] = 0; prdata[k] = 0; pslverr[k] = 0; rdy_cyc[k] = -1;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", gnt[0], 0);
        chk("rst_psel", psel[0], 0);
        chk("rst_rvalid", rvalid[0], 0);
        chk("rst_paddr", paddr[0], 0);
        chk("rst_pwdata", pwdata[0], 0);
        chk("rst_pstrb", pstrb[0], 0);
        chk("rst_rdata", rdata[0], 0);
        chk("rst_err", err[1], 0);
        chk("rst_timeout", tmo[1], 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run = 1'b1;

        // zero-wait read, unaligned address
        issue(0, 0, 32'h0000_3006, 4'hF, 32'h0, 32'hDEAD_BEEF, 0, 0, g);
        at(g + 1);
        chk("rd_paddr", paddr[0], 32'h0000_3004);
        chk("rd_pstrb", pstrb[0], 0);
        at(g + 3);
        chk("rd_rvalid", rvalid[0], 1);
        chk("rd_rdata", rdata[0], 32'hDEAD_BEEF);
        chk("rd_err", err[0], 0);
        at(g + 4);
        chk("rd_hold", rdata[0], 32'hDEAD_BEEF);
        @(posedge clk);
        #1;

        // write with five wait states
        issue(0, 1, 32'h0000_1008, 4'b0011, 32'h1234_5678, 32'hFFFF_FFFF, 0, 5, g);
        at(g + 7);
        chk("wr_pwdata", pwdata[0], 32'h1234_5678);
        chk("wr_pstrb", pstrb[0], 4'b0011);
        chk("wr_penable", penable[0], 1);
        at(g + 8);
        chk("wr_rvalid", rvalid[0], 1);
        chk("wr_rdata", rdata[0], 0);
        chk("wr_err", err[0], 0);
        @(posedge clk);
        #1;

        // slave error on a read
        issue(0, 0, 32'h0000_2000, 4'hF, 32'h0, 32'hCAFE_0001, 1, 1, g);
        at(g + 4);
        chk("se_rvalid", rvalid[0], 1);
        chk("se_err", err[0], 1);
        chk("se_rdata", rdata[0], 32'hCAFE_0001);
        @(posedge clk);
        #1;

        // back-to-back writes with req held
        issue(0, 1, 32'h0000_040F, 4'b1100, 32'hA5A5_0000, 32'h0, 0, 0, g);
        issue(0, 1, 32'h0000_0410, 4'b0001, 32'h0000_00FF, 32'h0, 0, 0, g2);
        chk("b2b_gnt_gap", g2, g + 4);
        at(g2 + 1);
        chk("b2b_paddr", paddr[0], 32'h0000_0410);
        chk("b2b_pstrb", pstrb[0], 4'b0001);
        at(g2 + 3);
        chk("b2b_rvalid", rvalid[0], 1);
        @(posedge clk);
        #1;

        // timeout abort, pready never arrives
        issue(1, 0, 32'h0000_5000, 4'hF, 32'h0, 32'h1111_2222, 0, 100, g);
        at(g + 5);
        chk("to_psel_last", psel[1], 1);
        chk("to_pulse_early", tmo[1], 0);
        at(g + 6);
        chk("to_rvalid", rvalid[1], 1);
        chk("to_err", err[1], 1);
        chk("to_pulse", tmo[1], 1);
        chk("to_psel", psel[1], 0);
        chk("to_rdata", rdata[1], 0);
        @(posedge clk);
        #1;

        // pready on the cycle the limit is reached
        issue(1, 0, 32'h0000_5004, 4'hF, 32'h0, 32'h3333_4444, 0, 3, g);
        at(g + 6);
        chk("lim_rvalid", rvalid[1], 1);
        chk("lim_timeout", tmo[1], 0);
        chk("lim_err", err[1], 0);
        chk("lim_rdata", rdata[1], 32'h3333_4444);
        @(posedge clk);
        #1;

        // reset in the middle of ACCESS
        issue(0, 1, 32'h0000_6000, 4'hF, 32'h0BAD_F00D, 32'h0, 0, 10, g);
        at(g + 3);
        @(posedge clk);
        #1;
        rst = 1'b1;
        rdy_cyc[0] = -1;
        for (int k = 0; k < N; k++) begin
            for (int c = g + 5; c < MAXC; c++) begin
                m_busy[k][c] = 0; m_psel[k][c] = 0; m_pen[k][c] = 0;
                m_rv[k][c] = 0; m_tmo[k][c] = 0;
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        at(g + 5);
        chk("mid_rst_psel", psel[0], 0);
        chk("mid_rst_penable", penable[0], 0);
        chk("mid_rst_gnt", gnt[0], 1);
        repeat (15) @(negedge clk);

        run = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
